// File: rtl/bit_serial_addsub_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller:
// FSM state encoding and the one-bit full-add function used by the slice.
package bit_serial_addsub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {carry, sum} of three input bits.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/bit_serial_addsub_ctrl_addsubn.sv
// One-bit add/subtract slice; b is inverted when subtract is high, and the
// caller supplies the initial carry that completes the two's complement.
module AddSubN
  import bit_serial_addsub_ctrl_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic subtract,
  output logic sum,
  output logic cout
);

  logic [1:0] fa;

  assign fa   = full_add(a, b ^ subtract, cin);
  assign sum  = fa[0];
  assign cout = fa[1];

endmodule

// File: rtl/bit_serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: latches operands on start and feeds
// them LSB first through a single AddSubN slice, one bit per clock.
module bit_serial_addsub_ctrl
  import bit_serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow
);

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic               sub_l;
  logic               carry_q;
  logic [CNT_W-1:0]   count;
  logic               slice_sum;
  logic               slice_cout;
  logic               last_bit;

  AddSubN slice (
    .a       (a_sh[0]),
    .b       (b_sh[0]),
    .cin     (carry_q),
    .subtract(sub_l),
    .sum     (slice_sum),
    .cout    (slice_cout)
  );

  assign last_bit = (count == CNT_W'(WIDTH - 1));

  // busy and done are registered alongside the state so neither has a
  // combinational path from start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      sub_l    <= 1'b0;
      carry_q  <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh     <= a;
            b_sh     <= b;
            sub_l    <= subtract;
            carry_q  <= subtract;
            count    <= '0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            state    <= ST_RUN;
            busy     <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          result  <= {slice_sum, result[WIDTH-1:1]};
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          carry_q <= slice_cout;
          count   <= count + CNT_W'(1);
          // On the MSB the carry flop holds the carry into the MSB.
          if (last_bit) begin
            carryout <= slice_cout;
            overflow <= carry_q ^ slice_cout;
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_addsub_ctrl.sv
// Self-checking bench: directed WIDTH=4 cases plus a WIDTH=32 random
// regression against a plain-arithmetic reference model.
module tb_bit_serial_addsub_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic        start4, sub4, busy4, done4, co4, ovf4;
  logic [3:0]  a4, b4, res4;
  logic        start32, sub32, busy32, done32, co32, ovf32;
  logic [31:0] a32, b32, res32;

  int compared = 0;
  int mismatched = 0;

  bit_serial_addsub_ctrl #(.WIDTH(4), .CNT_W(6)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .subtract(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .carryout(co4), .overflow(ovf4)
  );

  bit_serial_addsub_ctrl #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .subtract(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .carryout(co32), .overflow(ovf32)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Runs one 4-bit op. inject: cycle at which a bogus start is pulsed;
  // rst_at: cycle at which reset is pulsed; stop: return in the done cycle.
  task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic sub,
                                input int inject, input int rst_at, input bit stop,
                                output int done_at, output int done_cnt, output int busy_cnt);
    @(negedge clk);
    a4 = a; b4 = b; sub4 = sub; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    done_at = -1; done_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      if (busy4) busy_cnt++;
      if (rst_at >= 0 && i == rst_at + 1) begin
        checkOutput("rst_busy", 64'(busy4), 64'd0);
        checkOutput("rst_done", 64'(done4), 64'd0);
        checkOutput("rst_result", 64'(res4), 64'd0);
        checkOutput("rst_carry", 64'(co4), 64'd0);
        checkOutput("rst_ovf", 64'(ovf4), 64'd0);
      end
      if (stop && done4) return;
      start4 = (i == inject);
      if (i == inject) begin a4 = 4'hf; b4 = 4'hf; end
      reset = (i == rst_at);
      @(negedge clk);
    end
    reset = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic run32Regression(input int n_ops);
    logic [31:0] ea, eb, exp_res;
    logic        es, exp_co, exp_ovf;
    longint      sa, sb, sres;
    int          cyc;
    bit          got;
    @(negedge clk);
    ea = $urandom; eb = $urandom; es = 1'($urandom_range(0, 1));
    a32 = ea; b32 = eb; sub32 = es; start32 = 1'b1;
    for (int op = 0; op < n_ops; op++) begin
      @(negedge clk);
      start32 = 1'b0;
      got = 1'b0;
      cyc = 0;
      while (cyc < 40) begin
        if (done32) begin got = 1'b1; break; end
        @(negedge clk);
        cyc++;
      end
      checkOutput("r32_latency", 64'(cyc), 64'd32);
      if (!got) begin
        $display("[TB] FAIL r32_timeout observed=none expected=done");
        break;
      end
      exp_res = es ? ea - eb : ea + eb;
      exp_co  = es ? (ea >= eb) : ({1'b0, ea} + {1'b0, eb} > 33'hFFFFFFFF);
      sa = longint'($signed(ea));
      sb = longint'($signed(eb));
      sres = es ? sa - sb : sa + sb;
      exp_ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      checkOutput("r32_result", 64'(res32), 64'(exp_res));
      checkOutput("r32_carry", 64'(co32), 64'(exp_co));
      checkOutput("r32_ovf", 64'(ovf32), 64'(exp_ovf));
      if (op == n_ops - 1) break;
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      ea = $urandom; eb = $urandom; es = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) eb = ea;
      a32 = ea; b32 = eb; sub32 = es; start32 = 1'b1;
    end
    start32 = 1'b0;
  endtask

  initial begin
    int d_at, d_cnt, b_cnt;
    reset = 1'b1;
    start4 = 0; sub4 = 0; a4 = 0; b4 = 0;
    start32 = 0; sub32 = 0; a32 = 0; b32 = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy4), 64'd0);
    checkOutput("reset_done", 64'(done4), 64'd0);
    checkOutput("reset_result", 64'(res4), 64'd0);
    checkOutput("reset_carry", 64'(co4), 64'd0);
    checkOutput("reset_ovf", 64'(ovf4), 64'd0);
    reset = 1'b0;

    applyStimulus4(4'b0101, 4'b0011, 1'b0, -1, -1, 1'b0, d_at, d_cnt, b_cnt);
    checkOutput("add_done_at", 64'(d_at), 64'd4);
    checkOutput("add_busy_cycles", 64'(b_cnt), 64'd4);
    checkOutput("add_result", 64'(res4), 64'b1000);
    checkOutput("add_carry", 64'(co4), 64'd0);
    checkOutput("add_ovf", 64'(ovf4), 64'd1);

    applyStimulus4(4'b0011, 4'b0001, 1'b1, -1, -1, 1'b0, d_at, d_cnt, b_cnt);
    checkOutput("sub1_result", 64'(res4), 64'b0010);
    checkOutput("sub1_carry", 64'(co4), 64'd1);
    checkOutput("sub1_ovf", 64'(ovf4), 64'd0);

    applyStimulus4(4'b1000, 4'b0001, 1'b1, -1, -1, 1'b0, d_at, d_cnt, b_cnt);
    checkOutput("sub2_result", 64'(res4), 64'b0111);
    checkOutput("sub2_carry", 64'(co4), 64'd1);
    checkOutput("sub2_ovf", 64'(ovf4), 64'd1);

    applyStimulus4(4'b0001, 4'b0001, 1'b0, 1, -1, 1'b0, d_at, d_cnt, b_cnt);
    checkOutput("ign_result", 64'(res4), 64'b0010);
    checkOutput("ign_carry", 64'(co4), 64'd0);
    checkOutput("ign_ovf", 64'(ovf4), 64'd0);
    checkOutput("ign_done_pulses", 64'(d_cnt), 64'd1);
    checkOutput("ign_done_at", 64'(d_at), 64'd4);

    applyStimulus4(4'b0111, 4'b0111, 1'b0, -1, 1, 1'b0, d_at, d_cnt, b_cnt);
    checkOutput("abort_done_pulses", 64'(d_cnt), 64'd0);
    applyStimulus4(4'b0010, 4'b0001, 1'b0, -1, -1, 1'b0, d_at, d_cnt, b_cnt);
    checkOutput("after_abort_result", 64'(res4), 64'b0011);

    applyStimulus4(4'b0011, 4'b0001, 1'b0, -1, -1, 1'b1, d_at, d_cnt, b_cnt);
    checkOutput("b2b_first_done", 64'(done4), 64'd1);
    checkOutput("b2b_first_result", 64'(res4), 64'b0100);
    a4 = 4'b0111; b4 = 4'b0001; sub4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    checkOutput("b2b_no_bubble_busy", 64'(busy4), 64'd1);
    checkOutput("b2b_result_cleared", 64'(res4), 64'd0);
    d_at = -1;
    for (int i = 0; i < 12; i++) begin
      if (done4) begin d_at = i; break; end
      @(negedge clk);
    end
    checkOutput("b2b_done_at", 64'(d_at), 64'd4);
    checkOutput("b2b_second_result", 64'(res4), 64'b1000);
    checkOutput("b2b_second_ovf", 64'(ovf4), 64'd1);
    checkOutput("b2b_second_carry", 64'(co4), 64'd0);

    run32Regression(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
